// File: rtl/mem_intf_unit_p.sv
// Single-request memory interface: 4-phase read/write handshake to the SMM with timeout and illegal-request error.
// Optional macro MEM_INTF_RETRY_EN: re-issue a timed-out request up to MAX_RETRY times before reporting the error.
module mem_intf_unit_p #(
  parameter int ADDR_W    = 14,
  parameter int WDATA_W   = 16,
  parameter int RDATA_W   = 8,
  parameter int TIMEOUT   = 12,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               store,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WDATA_W-1:0] result,
  output logic               req_ready,
  output logic               mem_done,
  output logic               mem_err,
  output logic [RDATA_W-1:0] datatoinst,
  output logic               read_req,
  output logic               write_req,
  output logic [ADDR_W-1:0]  addrout,
  output logic [WDATA_W-1:0] datatomem,
  input  logic               mem_resp,
  input  logic [RDATA_W-1:0] datafrommem
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef MEM_INTF_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [RETRY_W-1:0]   r_retry;
  logic                 r_gap;
  logic                 r_is_load;
  logic                 r_req_ready, r_mem_done, r_mem_err, r_read_req, r_write_req;
  logic [RDATA_W-1:0]   r_datatoinst;
  logic [ADDR_W-1:0]    r_addrout;
  logic [WDATA_W-1:0]   r_datatomem;

  logic w_accept, w_illegal, w_resp_hit, w_tmo, w_retry_ok;

  assign w_accept   = r_req_ready && (load ^ store);
  assign w_illegal  = r_req_ready && load && store;
  // r_gap marks the one-cycle request drop between retry attempts
  assign w_resp_hit = !r_gap && mem_resp;
  assign w_tmo      = !r_gap && !mem_resp && (r_cnt == CNT_LAST);
  assign w_retry_ok = (RETRY_LIMIT != 0) && (r_retry != RETRY_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = REQ;
               else if (w_illegal) w_state_nxt = DONE;
      REQ:     if (w_resp_hit || (w_tmo && !w_retry_ok)) w_state_nxt = RELEASE;
      RELEASE: if (!mem_resp) w_state_nxt = IDLE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is withheld one extra cycle after DONE so an illegal request costs the same turnaround as the shortest legal one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready  <= 1'b0;
      r_mem_done   <= 1'b0;
      r_mem_err    <= 1'b0;
      r_read_req   <= 1'b0;
      r_write_req  <= 1'b0;
      r_datatoinst <= '0;
      r_addrout    <= '0;
      r_datatomem  <= '0;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_gap        <= 1'b0;
      r_is_load    <= 1'b0;
    end else begin
      r_mem_done  <= 1'b0;
      r_mem_err   <= 1'b0;
      r_req_ready <= (w_state_nxt == IDLE) && (r_state != DONE);
      case (r_state)
        IDLE: begin
          r_retry <= '0;
          r_gap   <= 1'b0;
          if (w_accept) begin
            r_addrout   <= addr;
            if (store) r_datatomem <= result;
            r_read_req  <= load;
            r_write_req <= store;
            r_is_load   <= load;
            r_cnt       <= '0;
          end else if (w_illegal) begin
            r_mem_done <= 1'b1;
            r_mem_err  <= 1'b1;
          end
        end
        REQ: begin
          if (r_gap) begin
            if (!mem_resp) begin
              r_read_req  <= r_is_load;
              r_write_req <= !r_is_load;
              r_gap       <= 1'b0;
            end
          end else if (mem_resp) begin
            if (r_is_load) r_datatoinst <= datafrommem;
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_mem_done  <= 1'b1;
          end else if (w_tmo) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_cnt       <= '0;
            if (w_retry_ok) begin
              r_gap   <= 1'b1;
              r_retry <= r_retry + RETRY_W'(1);
            end else begin
              r_mem_done <= 1'b1;
              r_mem_err  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign mem_done   = r_mem_done;
  assign mem_err    = r_mem_err;
  assign datatoinst = r_datatoinst;
  assign read_req   = r_read_req;
  assign write_req  = r_write_req;
  assign addrout    = r_addrout;
  assign datatomem  = r_datatomem;

endmodule

// File: tb/tb_mem_intf_unit_p.sv
// Directed bench for mem_intf_unit_p (default build: retry disabled, TIMEOUT=12).
module tb_mem_intf_unit_p;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, store, mem_resp;
  logic [13:0] addr;
  logic [15:0] result;
  logic [7:0]  datafrommem;
  logic        req_ready, mem_done, mem_err, read_req, write_req;
  logic [7:0]  datatoinst;
  logic [13:0] addrout;
  logic [15:0] datatomem;

  int n_checks = 0;
  int n_errors = 0;

  mem_intf_unit_p dut (
    .clk(clk), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
    .result(result), .req_ready(req_ready), .mem_done(mem_done), .mem_err(mem_err),
    .datatoinst(datatoinst), .read_req(read_req), .write_req(write_req),
    .addrout(addrout), .datatomem(datatomem), .mem_resp(mem_resp),
    .datafrommem(datafrommem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hi;
  logic to_done, to_err;
  int bad;

  initial begin
    reset_n = 1'b0; load = 0; store = 0; mem_resp = 0;
    addr = '0; result = '0; datafrommem = '0;
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_outs", {mem_done, mem_err, read_req, write_req}, 0);
    chk("rst_data", {addrout, datatomem, datatoinst}, 0);
    #9 reset_n = 1'b1;
    tick();
    chk("idle_ready", req_ready, 1);

    // load, response three cycles after read_req
    load = 1; addr = 14'h0123;
    tick();
    chk("ld_req", {read_req, write_req}, 2'b10);
    chk("ld_addr", addrout, 14'h0123);
    chk("ld_notready", req_ready, 0);
    load = 0; addr = '0;
    repeat (3) tick();
    chk("ld_hold", {read_req, addrout}, {1'b1, 14'h0123});
    mem_resp = 1; datafrommem = 8'hA5;
    tick();
    chk("ld_done", {mem_done, mem_err, read_req}, 3'b100);
    chk("ld_data", datatoinst, 8'hA5);
    tick();
    chk("ld_release", {req_ready, mem_done}, 2'b00);
    mem_resp = 0; datafrommem = 8'h00;
    tick();
    chk("ld_ready_back", req_ready, 1);

    // store, response after one cycle
    store = 1; addr = 14'h3FFF; result = 16'hBEEF;
    tick();
    chk("st_req", {read_req, write_req}, 2'b01);
    chk("st_bus", {addrout, datatomem}, {14'h3FFF, 16'hBEEF});
    store = 0; addr = '0; result = '0;
    tick();
    chk("st_stable", {write_req, addrout, datatomem}, {1'b1, 14'h3FFF, 16'hBEEF});
    mem_resp = 1;
    tick();
    chk("st_done", {mem_done, mem_err, write_req}, 3'b100);
    chk("st_keep_ld", datatoinst, 8'hA5);
    mem_resp = 0;
    tick();
    chk("st_ready_back", {req_ready, mem_done}, 2'b10);

    // timeout: read_req high exactly 12 cycles
    load = 1; addr = 14'h0055; datafrommem = 8'h3C;
    tick();
    load = 0;
    hi = read_req ? 1 : 0;
    to_done = 0; to_err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (read_req) hi++;
      else begin
        to_done = mem_done; to_err = mem_err;
        break;
      end
    end
    chk("to_len", hi, 12);
    chk("to_flags", {to_done, to_err}, 2'b11);
    chk("to_keep_ld", datatoinst, 8'hA5);
    tick();
    chk("to_pulse_end", {mem_done, mem_err, req_ready}, 3'b001);

    // illegal load+store
    load = 1; store = 1; addr = 14'h0111;
    tick();
    chk("il_flags", {mem_done, mem_err, read_req, write_req, req_ready}, 5'b11000);
    tick();
    chk("il_wait", {mem_done, mem_err, req_ready}, 3'b000);
    load = 0; store = 0;
    tick();
    chk("il_ready", {req_ready, read_req, write_req}, 3'b100);

    // held response after a store, load waiting
    store = 1; addr = 14'h0200; result = 16'h1234;
    tick();
    store = 0;
    chk("hr_st_req", write_req, 1);
    mem_resp = 1;
    tick();
    chk("hr_st_done", mem_done, 1);
    load = 1; addr = 14'h0300;
    bad = 0;
    repeat (5) begin
      tick();
      if (read_req !== 1'b0 || req_ready !== 1'b0) bad++;
    end
    chk("hr_blocked", bad, 0);
    mem_resp = 0;
    tick();
    chk("hr_ready", {req_ready, read_req}, 2'b10);
    tick();
    chk("hr_ld_req", {read_req, addrout}, {1'b1, 14'h0300});
    load = 0;
    mem_resp = 1; datafrommem = 8'h5A;
    tick();
    chk("hr_ld_done", {mem_done, mem_err, datatoinst}, {2'b10, 8'h5A});
    mem_resp = 0;
    tick();
    chk("hr_ready2", req_ready, 1);

    // asynchronous reset in the middle of a store
    store = 1; addr = 14'h2AAA; result = 16'hCAFE;
    tick();
    store = 0;
    tick();
    chk("ar_pre", {write_req, addrout, datatomem}, {1'b1, 14'h2AAA, 16'hCAFE});
    #2 reset_n = 1'b0;
    #1;
    chk("ar_clear", {write_req, addrout, datatomem}, 0);
    chk("ar_outs", {mem_done, mem_err, req_ready, datatoinst}, 0);
    @(posedge clk);
    #3;
    chk("ar_no_done", mem_done, 0);
    reset_n = 1'b1;
    tick();
    chk("ar_ready", {req_ready, write_req, mem_done}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
